// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage: ALU op decode, immediate select, forwarding, load-use stall
module alu_issue_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [4:0]    id_shamt,
    input  logic [15:0]   id_imm,
    input  logic [RA-1:0] id_rs,
    input  logic [RA-1:0] id_rt,
    input  logic [W-1:0]  id_rs_data,
    input  logic [W-1:0]  id_rt_data,
    input  logic [RA-1:0] id_dst,
    input  logic          exm_we,
    input  logic [RA-1:0] exm_dst,
    input  logic [W-1:0]  exm_data,
    input  logic          mwb_we,
    input  logic [RA-1:0] mwb_dst,
    input  logic [W-1:0]  mwb_data,
    input  logic          ex_hold,
    input  logic          flush,
    output logic          id_stall,
    output logic          ex_valid,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_ctr,
    output logic          ex_ovf_en,
    output logic          ex_is_load,
    output logic [RA-1:0] ex_dst,
    output logic [W-1:0]  ex_store_data,
    output logic          ex_illegal
);

    // ALU op encoding; bit 2 selects subtract in the adder
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        A_RS,
        A_SHAMT,
        A_LUI
    } a_sel_t;

    typedef enum logic [1:0] {
        B_RT,
        B_SEXT,
        B_ZEXT
    } b_sel_t;

    logic [3:0]    dec_ctr;
    a_sel_t        a_sel;
    b_sel_t        b_sel;
    logic          dec_ovf;
    logic          dec_load;
    logic          dec_illegal;
    logic          uses_rt;
    logic [W-1:0]  fwd_rs;
    logic [W-1:0]  fwd_rt;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;

    // EX/MEM beats MEM/WB; r0 is hard-wired and never forwarded
    function automatic logic [W-1:0] forward(
        input logic [RA-1:0] src,
        input logic [W-1:0]  rf_data
    );
        if (exm_we && exm_dst != '0 && exm_dst == src) begin
            return exm_data;
        end else if (mwb_we && mwb_dst != '0 && mwb_dst == src) begin
            return mwb_data;
        end else begin
            return rf_data;
        end
    endfunction

    // Opcode/funct decode into ALU op, operand selects and side flags
    always_comb begin
        dec_ctr     = ALU_AND;
        a_sel       = A_RS;
        b_sel       = B_RT;
        dec_ovf     = 1'b0;
        dec_load    = 1'b0;
        dec_illegal = 1'b0;
        uses_rt     = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                case (id_funct)
                    6'h20: begin dec_ctr = ALU_ADD; dec_ovf = 1'b1; end
                    6'h21: dec_ctr = ALU_ADD;
                    6'h22: begin dec_ctr = ALU_SUB; dec_ovf = 1'b1; end
                    6'h23: dec_ctr = ALU_SUB;
                    6'h24: dec_ctr = ALU_AND;
                    6'h25: dec_ctr = ALU_OR;
                    6'h26: dec_ctr = ALU_XOR;
                    6'h27: dec_ctr = ALU_NOR;
                    6'h2A: dec_ctr = ALU_SLT;
                    6'h00: begin dec_ctr = ALU_SLL; a_sel = A_SHAMT; end
                    6'h02: begin dec_ctr = ALU_SRL; a_sel = A_SHAMT; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin dec_ctr = ALU_ADD; b_sel = B_SEXT; dec_ovf = 1'b1; end
            OP_ADDIU: begin dec_ctr = ALU_ADD; b_sel = B_SEXT; end
            OP_SLTI:  begin dec_ctr = ALU_SLT; b_sel = B_SEXT; end
            OP_ANDI:  begin dec_ctr = ALU_AND; b_sel = B_ZEXT; end
            OP_ORI:   begin dec_ctr = ALU_OR;  b_sel = B_ZEXT; end
            OP_XORI:  begin dec_ctr = ALU_XOR; b_sel = B_ZEXT; end
            OP_LUI:   begin dec_ctr = ALU_SLL; a_sel = A_LUI; b_sel = B_ZEXT; end
            OP_LW:    begin dec_ctr = ALU_ADD; b_sel = B_SEXT; dec_load = 1'b1; end
            OP_SW:    begin dec_ctr = ALU_ADD; b_sel = B_SEXT; uses_rt = 1'b1; end
            OP_BEQ:   begin dec_ctr = ALU_SUB; uses_rt = 1'b1; end
            default:  dec_illegal = 1'b1;
        endcase
    end

    // Forwarding resolves before the immediate mux so sw data and beq compare see fresh values
    always_comb begin
        fwd_rs = forward(id_rs, id_rs_data);
        fwd_rt = forward(id_rt, id_rt_data);
        case (a_sel)
            A_SHAMT: op_a = {{(W-5){1'b0}}, id_shamt};
            A_LUI:   op_a = W'(16);
            default: op_a = fwd_rs;
        endcase
        case (b_sel)
            B_SEXT:  op_b = {{(W-16){id_imm[15]}}, id_imm};
            B_ZEXT:  op_b = {{(W-16){1'b0}}, id_imm};
            default: op_b = fwd_rt;
        endcase
    end

    // A load in EX cannot forward its data yet; hold IF/ID for one cycle on a dependency
    assign id_stall = id_valid & ex_valid & ex_is_load & (ex_dst != '0) &
                      ((ex_dst == id_rs) | (uses_rt & (ex_dst == id_rt)));

    // ID/EX register: flush > hold > stall bubble > capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_ctr       <= '0;
            ex_ovf_en     <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_dst        <= '0;
            ex_store_data <= '0;
            ex_illegal    <= 1'b0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_ovf_en  <= 1'b0;
            ex_is_load <= 1'b0;
            ex_dst     <= '0;
            ex_illegal <= 1'b0;
        end else if (!ex_hold) begin
            if (id_stall) begin
                ex_valid   <= 1'b0;
                ex_ovf_en  <= 1'b0;
                ex_is_load <= 1'b0;
                ex_dst     <= '0;
                ex_illegal <= 1'b0;
            end else begin
                ex_valid      <= id_valid;
                alu_a         <= op_a;
                alu_b         <= op_b;
                alu_ctr       <= dec_ctr;
                ex_store_data <= fwd_rt;
                ex_ovf_en     <= id_valid & dec_ovf;
                ex_is_load    <= id_valid & dec_load;
                ex_illegal    <= id_valid & dec_illegal;
                ex_dst        <= (id_valid && !dec_illegal) ? id_dst : '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_dst;
    logic        exm_we;
    logic [4:0]  exm_dst;
    logic [31:0] exm_data;
    logic        mwb_we;
    logic [4:0]  mwb_dst;
    logic [31:0] mwb_data;
    logic        ex_hold;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctr;
    logic        ex_ovf_en;
    logic        ex_is_load;
    logic [4:0]  ex_dst;
    logic [31:0] ex_store_data;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.W(32), .RA(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_shamt(id_shamt), .id_imm(id_imm), .id_rs(id_rs),
        .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_dst(id_dst),
        .exm_we(exm_we), .exm_dst(exm_dst), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_dst(mwb_dst), .mwb_data(mwb_data),
        .ex_hold(ex_hold), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .ex_ovf_en(ex_ovf_en),
        .ex_is_load(ex_is_load), .ex_dst(ex_dst), .ex_store_data(ex_store_data),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  dst;
        logic        xwe;
        logic [4:0]  xd;
        logic [31:0] xdata;
        logic        mwe;
        logic [4:0]  md;
        logic [31:0] mdata;
        logic        valid;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  ectr;
        logic        eovf;
        logic        eld;
        logic [4:0]  edst;
        logic        eill;
        logic [31:0] esd;
    } vec_t;

    vec_t tv[24];

    function automatic vec_t ins(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [31:0] rsd, input logic [31:0] rtd, input logic [4:0] dst);
        vec_t v;
        v.op = op; v.fn = fn; v.sh = sh; v.imm = imm; v.rs = rs; v.rt = rt;
        v.rsd = rsd; v.rtd = rtd; v.dst = dst;
        v.xwe = 1'b0; v.xd = 5'd0; v.xdata = 32'h0;
        v.mwe = 1'b0; v.md = 5'd0; v.mdata = 32'h0;
        v.valid = 1'b1;
        v.ea = '0; v.eb = '0; v.ectr = '0; v.eovf = 1'b0; v.eld = 1'b0;
        v.edst = '0; v.eill = 1'b0; v.esd = '0;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic [31:0] ea, input logic [31:0] eb,
                                input logic [3:0] ectr, input logic eovf, input logic eld,
                                input logic [4:0] edst, input logic eill, input logic [31:0] esd);
        vec_t v = vi;
        v.ea = ea; v.eb = eb; v.ectr = ectr; v.eovf = eovf; v.eld = eld;
        v.edst = edst; v.eill = eill; v.esd = esd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_opcode = v.op; id_funct = v.fn; id_shamt = v.sh; id_imm = v.imm;
        id_rs = v.rs; id_rt = v.rt; id_rs_data = v.rsd; id_rt_data = v.rtd; id_dst = v.dst;
        exm_we = v.xwe; exm_dst = v.xd; exm_data = v.xdata;
        mwb_we = v.mwe; mwb_dst = v.md; mwb_data = v.mdata;
        id_valid = v.valid;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(ex_valid), 32'h0);
        chk({tag, " alu_a"}, alu_a, 32'h0);
        chk({tag, " alu_b"}, alu_b, 32'h0);
        chk({tag, " alu_ctr"}, 32'(alu_ctr), 32'h0);
        chk({tag, " flags"}, {28'h0, ex_ovf_en, ex_is_load, ex_illegal, id_stall}, 32'h0);
        chk({tag, " dst"}, 32'(ex_dst), 32'h0);
        chk({tag, " store"}, ex_store_data, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        // R-type arithmetic/logic and shifts
        tv[0]  = ex(ins(6'h00, 6'h20, 0, 16'h0, 1, 2, 5, 7, 3), 5, 7, 2, 1, 0, 3, 0, 7);
        tv[1]  = ex(ins(6'h08, 6'h00, 0, 16'hFFFF, 1, 0, 5, 0, 4), 5, 32'hFFFFFFFF, 2, 1, 0, 4, 0, 0);
        tv[2]  = ex(ins(6'h0C, 6'h00, 0, 16'hFFFF, 1, 0, 5, 0, 4), 5, 32'h0000FFFF, 0, 0, 0, 4, 0, 0);
        v = ins(6'h00, 6'h21, 0, 16'h0, 4, 2, 1, 2, 6);
        v.xwe = 1; v.xd = 4; v.xdata = 32'hA; v.mwe = 1; v.md = 4; v.mdata = 32'hB;
        tv[3]  = ex(v, 32'hA, 2, 2, 0, 0, 6, 0, 2);
        v = ins(6'h00, 6'h25, 0, 16'h0, 0, 2, 32'h33, 7, 6);
        v.xwe = 1; v.xd = 0; v.xdata = 32'hA; v.mwe = 1; v.md = 0; v.mdata = 32'hB;
        tv[4]  = ex(v, 32'h33, 7, 1, 0, 0, 6, 0, 7);
        v = ins(6'h00, 6'h26, 0, 16'h0, 1, 2, 5, 7, 6);
        v.xwe = 1; v.xd = 5; v.xdata = 32'hA; v.mwe = 1; v.md = 2; v.mdata = 32'hB;
        tv[5]  = ex(v, 5, 32'hB, 3, 0, 0, 6, 0, 32'hB);
        v = ins(6'h00, 6'h27, 0, 16'h0, 1, 2, 5, 7, 6);
        v.xwe = 0; v.xd = 1; v.xdata = 32'hA;
        tv[6]  = ex(v, 5, 7, 4, 0, 0, 6, 0, 7);
        tv[7]  = ex(ins(6'h00, 6'h00, 3, 16'h0, 0, 2, 0, 32'h10, 6), 3, 32'h10, 8, 0, 0, 6, 0, 32'h10);
        tv[8]  = ex(ins(6'h00, 6'h02, 31, 16'h0, 0, 2, 0, 32'h80000000, 6), 31, 32'h80000000, 5, 0, 0, 6, 0, 32'h80000000);
        tv[9]  = ex(ins(6'h00, 6'h22, 0, 16'h0, 1, 2, 5, 7, 6), 5, 7, 6, 1, 0, 6, 0, 7);
        tv[10] = ex(ins(6'h00, 6'h23, 0, 16'h0, 1, 2, 5, 7, 6), 5, 7, 6, 0, 0, 6, 0, 7);
        tv[11] = ex(ins(6'h00, 6'h2A, 0, 16'h0, 1, 2, 5, 7, 6), 5, 7, 7, 0, 0, 6, 0, 7);
        // I-type immediates
        tv[12] = ex(ins(6'h0A, 6'h00, 0, 16'h8000, 1, 0, 5, 0, 4), 5, 32'hFFFF8000, 7, 0, 0, 4, 0, 0);
        tv[13] = ex(ins(6'h0D, 6'h00, 0, 16'h8001, 1, 0, 5, 0, 4), 5, 32'h00008001, 1, 0, 0, 4, 0, 0);
        tv[14] = ex(ins(6'h0E, 6'h00, 0, 16'h00F0, 1, 0, 5, 0, 4), 5, 32'h000000F0, 3, 0, 0, 4, 0, 0);
        tv[15] = ex(ins(6'h0F, 6'h00, 0, 16'h1234, 0, 0, 0, 0, 4), 16, 32'h00001234, 8, 0, 0, 4, 0, 0);
        tv[16] = ex(ins(6'h09, 6'h00, 0, 16'h8000, 1, 0, 5, 0, 4), 5, 32'hFFFF8000, 2, 0, 0, 4, 0, 0);
        tv[17] = ex(ins(6'h23, 6'h00, 0, 16'hFFFC, 1, 9, 100, 0, 9), 100, 32'hFFFFFFFC, 2, 0, 1, 9, 0, 0);
        tv[18] = ex(ins(6'h2B, 6'h00, 0, 16'h0004, 1, 2, 5, 7, 0), 5, 4, 2, 0, 0, 0, 0, 7);
        tv[19] = ex(ins(6'h04, 6'h00, 0, 16'h0010, 1, 2, 5, 7, 0), 5, 7, 6, 0, 0, 0, 0, 7);
        // illegal opcode / funct, and invalid slots
        tv[20] = ex(ins(6'h3F, 6'h00, 0, 16'h0, 1, 2, 5, 7, 7), 5, 7, 0, 0, 0, 0, 1, 7);
        tv[21] = ex(ins(6'h00, 6'h3F, 0, 16'h0, 1, 2, 5, 7, 7), 5, 7, 0, 0, 0, 0, 1, 7);
        v = ins(6'h00, 6'h20, 0, 16'h0, 1, 2, 5, 7, 3); v.valid = 0;
        tv[22] = ex(v, 5, 7, 2, 0, 0, 0, 0, 7);
        v = ins(6'h3F, 6'h00, 0, 16'h0, 1, 2, 5, 7, 3); v.valid = 0;
        tv[23] = ex(v, 5, 7, 0, 0, 0, 0, 0, 7);

        rst_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
        drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0));
        id_valid = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tv[i]);
            step();
            chk($sformatf("v%0d valid", i), 32'(ex_valid), 32'(tv[i].valid));
            chk($sformatf("v%0d alu_a", i), alu_a, tv[i].ea);
            chk($sformatf("v%0d alu_b", i), alu_b, tv[i].eb);
            chk($sformatf("v%0d alu_ctr", i), 32'(alu_ctr), 32'(tv[i].ectr));
            chk($sformatf("v%0d ovf_en", i), 32'(ex_ovf_en), 32'(tv[i].eovf));
            chk($sformatf("v%0d is_load", i), 32'(ex_is_load), 32'(tv[i].eld));
            chk($sformatf("v%0d dst", i), 32'(ex_dst), 32'(tv[i].edst));
            chk($sformatf("v%0d illegal", i), 32'(ex_illegal), 32'(tv[i].eill));
            chk($sformatf("v%0d store", i), ex_store_data, tv[i].esd);
        end

        // load-use on rt of an R-type: one stall, one bubble, then issue
        drive(ins(6'h23, 0, 0, 16'h0, 1, 8, 5, 0, 8));
        step();
        chk("lu load", 32'(ex_is_load), 32'h1);
        drive(ins(6'h00, 6'h22, 0, 16'h0, 1, 8, 5, 3, 9));
        #1;
        chk("lu stall", 32'(id_stall), 32'h1);
        step();
        chk("lu bubble valid", 32'(ex_valid), 32'h0);
        chk("lu bubble load", 32'(ex_is_load), 32'h0);
        chk("lu bubble dst", 32'(ex_dst), 32'h0);
        chk("lu stall drop", 32'(id_stall), 32'h0);
        step();
        chk("lu issue valid", 32'(ex_valid), 32'h1);
        chk("lu issue ctr", 32'(alu_ctr), 32'h6);
        chk("lu issue dst", 32'(ex_dst), 32'h9);

        // addi does not read rt, so no stall
        drive(ins(6'h23, 0, 0, 16'h0, 1, 8, 5, 0, 8));
        step();
        drive(ins(6'h08, 0, 0, 16'h1, 1, 8, 5, 0, 4));
        #1;
        chk("lu addi rt nostall", 32'(id_stall), 32'h0);
        step();
        chk("lu addi valid", 32'(ex_valid), 32'h1);

        // load to r0 never stalls
        drive(ins(6'h23, 0, 0, 16'h0, 1, 0, 5, 0, 0));
        step();
        drive(ins(6'h00, 6'h22, 0, 16'h0, 0, 0, 0, 0, 9));
        #1;
        chk("lu r0 nostall", 32'(id_stall), 32'h0);
        step();

        // hold freezes outputs; flush during hold empties the stage
        drive(ins(6'h00, 6'h20, 0, 16'h0, 1, 2, 5, 7, 3));
        step();
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(ins(6'h0C, 0, 0, 16'(k + 1), 1, 0, 99 + k, 0, 12));
            step();
            chk($sformatf("hold%0d alu_a", k), alu_a, 32'h5);
            chk($sformatf("hold%0d alu_b", k), alu_b, 32'h7);
            chk($sformatf("hold%0d ctr", k), 32'(alu_ctr), 32'h2);
            chk($sformatf("hold%0d valid", k), 32'(ex_valid), 32'h1);
        end
        flush = 1'b1;
        step();
        chk("flush valid", 32'(ex_valid), 32'h0);
        chk("flush dst", 32'(ex_dst), 32'h0);
        chk("flush ovf", 32'(ex_ovf_en), 32'h0);
        flush = 1'b0;
        ex_hold = 1'b0;

        // async reset mid-stall
        drive(ins(6'h23, 0, 0, 16'h0, 1, 8, 5, 0, 8));
        step();
        drive(ins(6'h00, 6'h22, 0, 16'h0, 1, 8, 5, 3, 9));
        #1;
        chk("rst pre stall", 32'(id_stall), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post rst valid", 32'(ex_valid), 32'h1);
        chk("post rst ctr", 32'(alu_ctr), 32'h6);
        chk("post rst a", alu_a, 32'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
